// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a handshaked load port.
// Direct mode holds the decoded line; scan mode walks all lines with dwell.
module decoder_nto2n_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 load_valid,
    input  logic [N-1:0]         load_code,
    output logic                 load_ready,
    output logic [(2**N)-1:0]    y,
    output logic [N-1:0]         idx,
    output logic                 active,
    output logic                 wrap
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [W-1:0]         y_q, y_d;
    logic [N-1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 mode_q, mode_d;
    logic                 wrap_q, wrap_d;
    logic                 accept;

    assign load_ready = en;
    assign accept     = load_valid && en;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            y_d     = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (en) begin
            if (accept) begin
                idx_d   = load_code;
                y_d     = W'(1) << load_code;
                cnt_d   = '0;
                mode_d  = mode;
                dwell_d = dwell;
                state_d = mode ? SCAN : DIRECT;
            end else if (state_q == SCAN && mode_q) begin
                if (cnt_q == dwell_q) begin
                    // Advancing past the last line wraps to line 0.
                    cnt_d  = '0;
                    idx_d  = idx_q + N'(1);
                    y_d    = W'(1) << (idx_q + N'(1));
                    wrap_d = (idx_q == {N{1'b1}});
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y      = y_q;
    assign idx    = idx_q;
    assign wrap   = wrap_q;
    assign active = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench for decoder_nto2n_seq: N=3 main instance plus
// N=1 and N=4 instances sharing control inputs.
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst_n, en, stop, mode;
    logic [3:0] dwell;

    logic       load_valid;
    logic [2:0] load_code;
    logic       load_ready;
    logic [7:0] y;
    logic [2:0] idx;
    logic       active, wrap;

    logic       ld1;
    logic [0:0] code1;
    logic       rdy1;
    logic [1:0] y1;
    logic [0:0] idx1;
    logic       act1, wrap1;

    logic        ld4;
    logic [3:0]  code4;
    logic        rdy4;
    logic [15:0] y4;
    logic [3:0]  idx4;
    logic        act4, wrap4;

    int n_chk  = 0;
    int n_fail = 0;
    bit inv_on = 1'b0;

    always #5 clk = ~clk;

    decoder_nto2n_seq #(.N(3), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stop(stop),
        .mode(mode), .dwell(dwell),
        .load_valid(load_valid), .load_code(load_code),
        .load_ready(load_ready), .y(y), .idx(idx),
        .active(active), .wrap(wrap)
    );

    decoder_nto2n_seq #(.N(1), .DWELL_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .stop(stop),
        .mode(mode), .dwell(dwell),
        .load_valid(ld1), .load_code(code1),
        .load_ready(rdy1), .y(y1), .idx(idx1),
        .active(act1), .wrap(wrap1)
    );

    decoder_nto2n_seq #(.N(4), .DWELL_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .stop(stop),
        .mode(mode), .dwell(dwell),
        .load_valid(ld4), .load_code(code4),
        .load_ready(rdy4), .y(y4), .idx(idx4),
        .active(act4), .wrap(wrap4)
    );

    typedef struct {
        logic       ld;
        logic [2:0] code;
        logic       m;
        logic [3:0] dw;
        logic [7:0] ey;
        logic [2:0] eidx;
        logic       eact;
        logic       ewrap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic [2:0] code, logic m,
                                logic [3:0] dw, logic [7:0] ey,
                                logic [2:0] eidx, logic eact,
                                logic ewrap);
        vec_t v;
        v.ld = ld; v.code = code; v.m = m; v.dw = dw;
        v.ey = ey; v.eidx = eidx; v.eact = eact; v.ewrap = ewrap;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string nm, input logic [7:0] ey,
                            input logic [2:0] ei, input logic ea,
                            input logic ew);
        chk({nm, ".y"}, 32'(y), 32'(ey));
        chk({nm, ".idx"}, 32'(idx), 32'(ei));
        chk({nm, ".active"}, 32'(active), 32'(ea));
        chk({nm, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    // One-hot invariant on every instance, every cycle.
    always @(negedge clk) begin
        if (inv_on) begin
            n_chk++;
            if (!((active && y == (8'd1 << idx)) || (!active && y == 8'd0))) begin
                n_fail++;
                $display("FAIL inv3: y=%0h idx=%0d active=%0b", y, idx, active);
            end
            n_chk++;
            if (!((act1 && y1 == (2'd1 << idx1)) || (!act1 && y1 == 2'd0))) begin
                n_fail++;
                $display("FAIL inv1: y=%0h idx=%0d active=%0b", y1, idx1, act1);
            end
            n_chk++;
            if (!((act4 && y4 == (16'd1 << idx4)) || (!act4 && y4 == 16'd0))) begin
                n_fail++;
                $display("FAIL inv4: y=%0h idx=%0d active=%0b", y4, idx4, act4);
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; stop = 1'b0; mode = 1'b0; dwell = 4'd0;
        load_valid = 1'b0; load_code = 3'd0;
        ld1 = 1'b0; code1 = 1'b0; ld4 = 1'b0; code4 = 4'd0;

        cyc();
        cyc();
        chk_main("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset.y1", 32'(y1), 32'd0);
        chk("reset.y4", 32'(y4), 32'd0);
        chk("reset.ready_en1", 32'(load_ready), 32'd1);
        en = 1'b0;
        #1;
        chk("reset.ready_en0", 32'(load_ready), 32'd0);
        en = 1'b1;
        rst_n = 1'b1;
        inv_on = 1'b1;
        cyc();
        chk_main("idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Direct loads, hold, then a dwell=2 scan from 6 crossing the wrap.
        tbl.push_back(mk(1, 3'd0, 0, 4'd0, 8'h01, 3'd0, 1, 0));
        tbl.push_back(mk(1, 3'd1, 0, 4'd0, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 3'd2, 0, 4'd0, 8'h04, 3'd2, 1, 0));
        tbl.push_back(mk(1, 3'd3, 0, 4'd0, 8'h08, 3'd3, 1, 0));
        tbl.push_back(mk(1, 3'd4, 0, 4'd0, 8'h10, 3'd4, 1, 0));
        tbl.push_back(mk(1, 3'd5, 0, 4'd0, 8'h20, 3'd5, 1, 0));
        tbl.push_back(mk(1, 3'd6, 0, 4'd0, 8'h40, 3'd6, 1, 0));
        tbl.push_back(mk(1, 3'd7, 0, 4'd0, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(0, 3'd2, 0, 4'd0, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(0, 3'd3, 1, 4'd0, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(1, 3'd6, 1, 4'd2, 8'h40, 3'd6, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h40, 3'd6, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h40, 3'd6, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h01, 3'd0, 1, 1));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h01, 3'd0, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h01, 3'd0, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 4'd0, 8'h02, 3'd1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            load_valid = tbl[i].ld;
            load_code  = tbl[i].code;
            mode       = tbl[i].m;
            dwell      = tbl[i].dw;
            cyc();
            chk_main($sformatf("vec%0d", i), tbl[i].ey, tbl[i].eidx,
                     tbl[i].eact, tbl[i].ewrap);
        end

        // Load at idx 0 must not pulse wrap; dwell=0 shifts every cycle.
        load_valid = 1'b1; load_code = 3'd0; mode = 1'b1; dwell = 4'd0;
        cyc();
        chk_main("d0.load", 8'h01, 3'd0, 1'b1, 1'b0);
        load_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            logic [2:0] e;
            e = 3'(i % 8);
            cyc();
            chk_main($sformatf("d0.c%0d", i), 8'd1 << e, e, 1'b1,
                     (e == 3'd0));
        end

        // en low mid-scan (dwell=1): freeze and reject loads.
        load_valid = 1'b1; load_code = 3'd2; mode = 1'b1; dwell = 4'd1;
        cyc();
        chk_main("en.load", 8'h04, 3'd2, 1'b1, 1'b0);
        load_valid = 1'b0;
        cyc();
        chk_main("en.dw1", 8'h04, 3'd2, 1'b1, 1'b0);
        en = 1'b0; load_valid = 1'b1; load_code = 3'd7; mode = 1'b0;
        #1;
        chk("en.ready", 32'(load_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_main($sformatf("en.frz%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
        end
        en = 1'b1; load_valid = 1'b0;
        cyc();
        chk_main("en.resume", 8'h08, 3'd3, 1'b1, 1'b0);
        cyc();
        chk_main("en.hold", 8'h08, 3'd3, 1'b1, 1'b0);
        cyc();
        chk_main("en.next", 8'h10, 3'd4, 1'b1, 1'b0);

        // stop with a simultaneous load: stop wins.
        stop = 1'b1; load_valid = 1'b1; load_code = 3'd5; mode = 1'b0;
        cyc();
        chk_main("stop", 8'h00, 3'd0, 1'b0, 1'b0);
        stop = 1'b0; load_valid = 1'b0;
        cyc();
        chk_main("stop.idle", 8'h00, 3'd0, 1'b0, 1'b0);
        load_valid = 1'b1;
        cyc();
        chk_main("stop.reload", 8'h20, 3'd5, 1'b1, 1'b0);
        load_valid = 1'b0; en = 1'b0; stop = 1'b1;
        cyc();
        chk_main("stop.en0", 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1; stop = 1'b0;

        // Reset on the edge that would have wrapped.
        load_valid = 1'b1; load_code = 3'd7; mode = 1'b1; dwell = 4'd0;
        cyc();
        chk_main("rst.load", 8'h80, 3'd7, 1'b1, 1'b0);
        load_valid = 1'b0; rst_n = 1'b0;
        cyc();
        chk_main("rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk_main("rst.after1", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc();
        chk_main("rst.after2", 8'h00, 3'd0, 1'b0, 1'b0);

        // N=1 scan toggles; wrap on each return to 0.
        ld1 = 1'b1; code1 = 1'b0; mode = 1'b1; dwell = 4'd0;
        cyc();
        chk("n1.y0", 32'(y1), 32'h1);
        chk("n1.w0", 32'(wrap1), 32'd0);
        ld1 = 1'b0;
        cyc();
        chk("n1.y1", 32'(y1), 32'h2);
        chk("n1.w1", 32'(wrap1), 32'd0);
        cyc();
        chk("n1.y2", 32'(y1), 32'h1);
        chk("n1.w2", 32'(wrap1), 32'd1);
        cyc();
        chk("n1.y3", 32'(y1), 32'h2);
        chk("n1.w3", 32'(wrap1), 32'd0);
        cyc();
        chk("n1.y4", 32'(y1), 32'h1);
        chk("n1.w4", 32'(wrap1), 32'd1);

        // N=4 scan across the wrap, then a direct load.
        ld4 = 1'b1; code4 = 4'd14; mode = 1'b1; dwell = 4'd0;
        cyc();
        chk("n4.y0", 32'(y4), 32'h4000);
        ld4 = 1'b0;
        cyc();
        chk("n4.y1", 32'(y4), 32'h8000);
        chk("n4.w1", 32'(wrap4), 32'd0);
        cyc();
        chk("n4.y2", 32'(y4), 32'h0001);
        chk("n4.w2", 32'(wrap4), 32'd1);
        ld4 = 1'b1; code4 = 4'd9; mode = 1'b0;
        cyc();
        chk("n4.y3", 32'(y4), 32'h0200);
        chk("n4.i3", 32'(idx4), 32'd9);
        ld4 = 1'b0;
        cyc();
        chk("n4.hold", 32'(y4), 32'h0200);

        rst_n = 1'b0;
        cyc();
        chk("n1.rst", 32'(y1), 32'd0);
        chk("n1.rst_act", 32'(act1), 32'd0);
        chk("n4.rst", 32'(y4), 32'd0);
        chk("n4.rst_act", 32'(act4), 32'd0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("n1.stay", 32'(y1), 32'd0);
        chk("n4.stay", 32'(y4), 32'd0);

        inv_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
